// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace buffer: event codes, FSM states and record layout.
// TRACE_CYCLE_STAMP_EN appends a cycle-count stamp below the base record.
package trace_pkg;

  localparam logic [2:0] EV_NOP  = 3'd0;
  localparam logic [2:0] EV_ST   = 3'd1;
  localparam logic [2:0] EV_REG  = 3'd2;
  localparam logic [2:0] EV_LD   = 3'd3;
  localparam logic [2:0] EV_STU  = 3'd4;
  localparam logic [2:0] EV_HALT = 3'd5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Base record, MSB first: type, inum, pc, wr_reg, wr_data, mem_addr, mem_data
  localparam int REC_BASE_W = 86;
  localparam int OFF_MDATA  = 0;
  localparam int OFF_MADDR  = 16;
  localparam int OFF_WDATA  = 32;
  localparam int OFF_WREG   = 48;
  localparam int OFF_PC     = 51;
  localparam int OFF_INUM   = 67;
  localparam int OFF_TYPE   = 83;

`ifdef TRACE_CYCLE_STAMP_EN
  localparam bit STAMP_EN = 1'b1;
`else
  localparam bit STAMP_EN = 1'b0;
`endif

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags; head is presented from the storage registers.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 86
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       push,
  input  logic [W-1:0]               pushData,
  input  logic                       pop,
  output logic [W-1:0]               headData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   countQ, countNext;
  logic          fullQ, emptyQ;
  logic          doPush, doPop;

  assign doPush = push && !fullQ;
  assign doPop  = pop && !emptyQ;

  always_comb begin
    countNext = countQ;
    if (doPush && !doPop)
      countNext = countQ + 1'b1;
    else if (doPop && !doPush)
      countNext = countQ - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (doPush)
      mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
      fullQ  <= 1'b0;
      emptyQ <= 1'b1;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + 1'b1;
      if (doPop)
        rdPtr <= rdPtr + 1'b1;
      countQ <= countNext;
      fullQ  <= (countNext == FULL_LVL);
      emptyQ <= (countNext == '0);
    end
  end

  // Head reads as zero while empty so the record bus is clean out of reset.
  assign headData = emptyQ ? '0 : mem[rdPtr];
  assign full     = fullQ;
  assign empty    = emptyQ;
  assign level    = countQ;

endmodule

// File: rtl/retire_trace_buffer.sv
// Commit trace capture: classifies retirement events, numbers them, buffers them and streams records.
// Optional TRACE_CYCLE_STAMP_EN adds a low-order cycle_count stamp to each record.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 32,
  localparam int REC_W = REC_BASE_W + (STAMP_EN ? CNT_W : 0)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [15:0]      pc,
  input  logic             reg_wr,
  input  logic [2:0]       wr_reg,
  input  logic [15:0]      wr_data,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data,
  input  logic             halt,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [REC_W-1:0] rec_data,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic             overflow,
  output logic             done
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  state_t                  stateQ;
  logic [CNT_W-1:0]        cycleCountQ, instCountQ;
  logic                    overflowQ;
  logic [REC_BASE_W-1:0]   baseRec_p0;
  logic [REC_W-1:0]        evtRec_p0;
  logic [REC_W-1:0]        headRec;
  logic                    fifoFull, fifoEmpty;
  logic [LW-1:0]           fifoLevel;
  logic                    accept, dropEvt, recValid, pop, drainEnd;

  // Classification: fields outside the event type stay zero.
  always_comb begin
    baseRec_p0 = '0;
    baseRec_p0[OFF_PC +: 16]   = pc;
    baseRec_p0[OFF_INUM +: 16] = instCountQ[15:0];
    if (halt) begin
      baseRec_p0[OFF_TYPE +: 3] = EV_HALT;
    end else if (reg_wr && mem_wr) begin
      baseRec_p0[OFF_TYPE +: 3]   = EV_STU;
      baseRec_p0[OFF_WREG +: 3]   = wr_reg;
      baseRec_p0[OFF_WDATA +: 16] = wr_data;
      baseRec_p0[OFF_MADDR +: 16] = mem_addr;
      baseRec_p0[OFF_MDATA +: 16] = mem_data;
    end else if (reg_wr && mem_rd) begin
      baseRec_p0[OFF_TYPE +: 3]   = EV_LD;
      baseRec_p0[OFF_WREG +: 3]   = wr_reg;
      baseRec_p0[OFF_WDATA +: 16] = wr_data;
      baseRec_p0[OFF_MADDR +: 16] = mem_addr;
    end else if (reg_wr) begin
      baseRec_p0[OFF_TYPE +: 3]   = EV_REG;
      baseRec_p0[OFF_WREG +: 3]   = wr_reg;
      baseRec_p0[OFF_WDATA +: 16] = wr_data;
    end else if (mem_wr) begin
      baseRec_p0[OFF_TYPE +: 3]   = EV_ST;
      baseRec_p0[OFF_MADDR +: 16] = mem_addr;
      baseRec_p0[OFF_MDATA +: 16] = mem_data;
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  assign evtRec_p0 = {baseRec_p0, cycleCountQ};
`else
  assign evtRec_p0 = baseRec_p0;
`endif

  // Full is the registered flag, so a same-cycle pop never makes room for a push.
  assign accept   = commit_valid && (stateQ == RUN) && !fifoFull;
  assign dropEvt  = commit_valid && (stateQ == RUN) && fifoFull;
  assign recValid = !fifoEmpty && (stateQ != DONE);
  assign pop      = recValid && rec_ready;
  assign drainEnd = (fifoLevel == '0) || ((fifoLevel == LVL_ONE) && pop);

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) uFifo (
    .clk      (clk),
    .rstN     (rst),
    .push     (accept),
    .pushData (evtRec_p0),
    .pop      (pop),
    .headData (headRec),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (fifoLevel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ      <= RUN;
      cycleCountQ <= '0;
      instCountQ  <= '0;
      overflowQ   <= 1'b0;
    end else begin
      if (stateQ != DONE)
        cycleCountQ <= cycleCountQ + 1'b1;
      if (accept)
        instCountQ <= instCountQ + 1'b1;
      if (dropEvt)
        overflowQ <= 1'b1;
      case (stateQ)
        RUN:     if (accept && halt) stateQ <= DRAIN;
        DRAIN:   if (drainEnd) stateQ <= DONE;
        DONE:    stateQ <= DONE;
        default: stateQ <= RUN;
      endcase
    end
  end

  assign rec_valid   = recValid;
  assign rec_data    = headRec;
  assign cycle_count = cycleCountQ;
  assign inst_count  = instCountQ;
  assign overflow    = overflowQ;
  assign done        = (stateQ == DONE);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer against a queue-based reference model.
module tb_retire_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int REC_W = 86 + CNT_W;
`else
  localparam int REC_W = 86;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             commit_valid, reg_wr, mem_rd, mem_wr, halt, rec_ready;
  logic [15:0]      pc, wr_data, mem_addr, mem_data;
  logic [2:0]       wr_reg;
  logic             rec_valid, overflow, done;
  logic [REC_W-1:0] rec_data;
  logic [CNT_W-1:0] cycle_count, inst_count;

  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc), .reg_wr(reg_wr),
    .wr_reg(wr_reg), .wr_data(wr_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_data(rec_data), .cycle_count(cycle_count),
    .inst_count(inst_count), .overflow(overflow), .done(done)
  );

  // Reference model: record queue, counters, and a run/drain/done phase (0/1/2)
  logic [REC_W-1:0] q[$];
  int               mPhase;
  logic [CNT_W-1:0] mInst, mCyc;
  logic             mOvf;
  int               tests = 0;
  int               fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [85:0] baseOf(input logic [REC_W-1:0] r);
    return r[REC_W-1 -: 86];
  endfunction

  function automatic logic [REC_W-1:0] modelRec();
    logic [2:0]  ty = 3'd0;
    logic [2:0]  wr = 3'd0;
    logic [15:0] wd = 16'd0, ma = 16'd0, md = 16'd0;
    logic [85:0] b;
    if (halt) ty = 3'd5;
    else if (reg_wr && mem_wr) begin ty = 3'd4; wr = wr_reg; wd = wr_data; ma = mem_addr; md = mem_data; end
    else if (reg_wr && mem_rd) begin ty = 3'd3; wr = wr_reg; wd = wr_data; ma = mem_addr; end
    else if (reg_wr) begin ty = 3'd2; wr = wr_reg; wd = wr_data; end
    else if (mem_wr) begin ty = 3'd1; ma = mem_addr; md = mem_data; end
    b = {ty, mInst[15:0], pc, wr, wd, ma, md};
`ifdef TRACE_CYCLE_STAMP_EN
    return {b, mCyc};
`else
    return b;
`endif
  endfunction

  task automatic modelReset();
    q.delete();
    mPhase = 0;
    mInst  = '0;
    mCyc   = '0;
    mOvf   = 1'b0;
  endtask

  task automatic checkOutputs();
    logic expV;
    expV = (q.size() > 0) && (mPhase != 2);
    chk("rec_valid", rec_valid, expV);
    if (expV) chk("rec_data", rec_data, q[0]);
    chk("done", done, mPhase == 2);
    chk("overflow", overflow, mOvf);
    chk("inst_count", inst_count, mInst);
    chk("cycle_count", cycle_count, mCyc);
  endtask

  // Check current outputs, advance the model by one cycle, then cross the clock edge.
  task automatic step();
    int   s0;
    logic fullNow, doPop;
    checkOutputs();
    s0      = mPhase;
    fullNow = (q.size() == DEPTH);
    doPop   = (q.size() > 0) && (s0 != 2) && rec_ready;
    if (doPop) void'(q.pop_front());
    if (s0 == 0 && commit_valid) begin
      if (!fullNow) begin
        q.push_back(modelRec());
        mInst++;
        if (halt) mPhase = 1;
      end else begin
        mOvf = 1'b1;
      end
    end
    if (s0 == 1 && q.size() == 0) mPhase = 2;
    if (s0 != 2) mCyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    commit_valid = 0; reg_wr = 0; mem_rd = 0; mem_wr = 0; halt = 0;
    pc = '0; wr_reg = '0; wr_data = '0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic randFields(input logic allowHalt);
    pc = 16'($urandom); wr_reg = 3'($urandom); wr_data = 16'($urandom);
    mem_addr = 16'($urandom); mem_data = 16'($urandom);
    reg_wr = 1'($urandom); mem_rd = 1'($urandom); mem_wr = 1'($urandom);
    halt = allowHalt ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    modelReset();
    checkOutputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [85:0] b;
    logic [2:0]  lastType;
    logic [CNT_W-1:0] cap;
    int dutPops;

    clearIn();
    rec_ready = 1'b0;
    #2;
    doReset();

    // Test 1: single register-write commit
    commit_valid = 1; reg_wr = 1; wr_reg = 3'd3; wr_data = 16'h1234; pc = 16'h0002;
    step();
    clearIn();
    b = baseOf(rec_data);
    chk("t1 rec_valid", rec_valid, 1'b1);
    chk("t1 type", b[85:83], 3'd2);
    chk("t1 inum", b[82:67], 16'd0);
    chk("t1 pc", b[66:51], 16'h0002);
    chk("t1 wr_data", b[47:32], 16'h1234);
    chk("t1 inst_count", inst_count, 1);
    rec_ready = 1;
    step();

    // Test 2: store-update then a plain load-without-write (NOP)
    commit_valid = 1; reg_wr = 1; mem_wr = 1; wr_reg = 3'd5; wr_data = 16'h00AA;
    mem_addr = 16'h0040; mem_data = 16'hBEEF; pc = 16'h0004;
    step();
    clearIn();
    commit_valid = 1; mem_rd = 1; mem_addr = 16'h0080; pc = 16'h0006;
    b = baseOf(rec_data);
    chk("t2 stu type", b[85:83], 3'd4);
    chk("t2 stu addr", b[31:16], 16'h0040);
    chk("t2 stu data", b[15:0], 16'hBEEF);
    chk("t2 stu wr_data", b[47:32], 16'h00AA);
    step();
    clearIn();
    b = baseOf(rec_data);
    chk("t2 nop type", b[85:83], 3'd0);
    chk("t2 nop addr", b[31:16], 16'h0000);
    step();

    // Randomised traffic with back-pressure, no halt
    for (int i = 0; i < 200; i++) begin
      randFields(1'b0);
      commit_valid = ($urandom_range(0, 3) != 0);
      rec_ready = 1'($urandom);
      step();
    end
    clearIn();

    // Test 3: overflow with consumer stalled, then in-order drain
    doReset();
    rec_ready = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      randFields(1'b0);
      commit_valid = 1;
      step();
    end
    clearIn();
    chk("t3 overflow", overflow, 1'b1);
    chk("t3 inst_count", inst_count, DEPTH);
    rec_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      b = baseOf(rec_data);
      chk("t3 inum", b[82:67], 16'(i));
      step();
    end
    chk("t3 empty", rec_valid, 1'b0);

    // Test 4: halt with two records queued, commit_valid held, ready toggling
    doReset();
    rec_ready = 0;
    for (int i = 0; i < 2; i++) begin
      randFields(1'b0);
      commit_valid = 1;
      step();
    end
    clearIn();
    commit_valid = 1; halt = 1; pc = 16'h0020;
    step();
    dutPops = 0;
    lastType = 3'd7;
    for (int i = 0; i < 14; i++) begin
      randFields(1'b1);
      commit_valid = 1;
      rec_ready = (i % 2 == 0);
      if (rec_valid && rec_ready) begin
        dutPops++;
        b = baseOf(rec_data);
        lastType = b[85:83];
      end
      step();
    end
    chk("t4 records", dutPops, 3);
    chk("t4 last type", lastType, 3'd5);
    chk("t4 done", done, 1'b1);
    cap = cycle_count;
    step();
    step();
    chk("t4 cycle frozen", cycle_count, cap);
    clearIn();

    // Test 5: asynchronous reset while draining a non-empty FIFO
    doReset();
    rec_ready = 0;
    for (int i = 0; i < 3; i++) begin
      randFields(1'b0);
      commit_valid = 1;
      step();
    end
    clearIn();
    commit_valid = 1; halt = 1; pc = 16'h0030;
    step();
    clearIn();
    step();
    step();
    chk("t5 pre valid", rec_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("t5 rec_valid", rec_valid, 1'b0);
    chk("t5 inst_count", inst_count, 0);
    chk("t5 cycle_count", cycle_count, 0);
    chk("t5 done", done, 1'b0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    commit_valid = 1; reg_wr = 1; wr_reg = 3'd1; wr_data = 16'h5555; pc = 16'h0100;
    step();
    clearIn();
    chk("t5 run accept", rec_valid, 1'b1);
    rec_ready = 1;
    step();
    step();

`ifdef TRACE_CYCLE_STAMP_EN
    // Test 6: stamp equals cycle_count at accept
    doReset();
    rec_ready = 0;
    for (int i = 0; i < 4; i++) step();
    commit_valid = 1; mem_wr = 1; mem_addr = 16'h0010; mem_data = 16'h0001;
    step();
    clearIn();
    chk("t6 stamp", rec_data[CNT_W-1:0], 4);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
